// File: rtl/alu_exec_ctrl.sv
// Multi-cycle ALU control and execute unit for the EX stage.
// Decodes ALUop/funct/opcode, runs single-cycle ops directly and mul/div iteratively.
module alu_exec_ctrl #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [5:0]       opcode,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       control_out,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             illegal,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state, state_nxt;
  logic [3:0]         dec_code;
  logic [WIDTH-1:0]   alu_res;
  logic [SHW:0]       cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nxt;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_nxt;
  logic               last_step;

  assign in_ready  = (state == IDLE);
  assign last_step = (cnt == (SHW+1)'(1));

  always_comb begin
    dec_code = 4'd3;
    if (alu_op == 2'b00) begin
      dec_code = 4'd2;
    end else if (alu_op[0]) begin
      dec_code = 4'd6;
    end else begin
      case (funct)
        6'h20:   dec_code = 4'd2;
        6'h22:   dec_code = 4'd6;
        6'h24:   dec_code = 4'd0;
        6'h25:   dec_code = 4'd1;
        6'h2A:   dec_code = 4'd7;
        6'h1A:   dec_code = 4'd4;
        6'h00:   dec_code = 4'd8;
        6'h03:   dec_code = 4'd12;
        6'h26:   dec_code = 4'd10;
        6'h27:   dec_code = 4'd11;
        6'h02:   dec_code = (opcode != 6'h00) ? 4'd5 : 4'd9;
        default: dec_code = 4'd3;
      endcase
    end
  end

  always_comb begin
    alu_res = '0;
    case (dec_code)
      4'd0:    alu_res = opa & opb;
      4'd1:    alu_res = opa | opb;
      4'd2:    alu_res = opa + opb;
      4'd6:    alu_res = opa - opb;
      4'd7:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(opa) < $signed(opb))};
      4'd8:    alu_res = opb << shamt;
      4'd9:    alu_res = opb >> shamt;
      4'd12:   alu_res = $signed(opb) >>> shamt;
      4'd10:   alu_res = opa ^ opb;
      4'd11:   alu_res = ~(opa | opb);
      default: alu_res = '0;
    endcase
  end

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  always_comb begin
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_nxt   = {mul_sum, acc[WIDTH-1:1]};
    div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    div_nxt   = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (dec_code == 4'd5)                        state_nxt = MUL;
          else if (dec_code == 4'd4 && opb != '0)      state_nxt = DIV;
          else                                         state_nxt = DONE;
        end
      end
      MUL, DIV: if (last_step) state_nxt = DONE;
      DONE:     if (out_valid && out_ready) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // DONE entered from IDLE keeps out_valid low for one cycle so results appear at k+1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      control_out <= 4'd3;
      result      <= '0;
      result_hi   <= '0;
      illegal     <= 1'b0;
      div_by_zero <= 1'b0;
      acc         <= '0;
      opnd        <= '0;
      cnt         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            control_out <= dec_code;
            illegal     <= 1'b0;
            div_by_zero <= 1'b0;
            result      <= '0;
            result_hi   <= '0;
            opnd        <= opb;
            acc         <= {{WIDTH{1'b0}}, opa};
            cnt         <= (SHW+1)'(WIDTH);
            case (dec_code)
              4'd5: ;
              4'd4: begin
                if (opb == '0) begin
                  result      <= '1;
                  result_hi   <= opa;
                  div_by_zero <= 1'b1;
                end
              end
              4'd3:    illegal <= 1'b1;
              default: result  <= alu_res;
            endcase
          end
        end
        MUL: begin
          acc <= mul_nxt;
          cnt <= cnt - 1'b1;
          if (last_step) begin
            {result_hi, result} <= mul_nxt;
            out_valid           <= 1'b1;
          end
        end
        DIV: begin
          acc <= div_nxt;
          cnt <= cnt - 1'b1;
          if (last_step) begin
            result    <= div_nxt[WIDTH-1:0];
            result_hi <= div_nxt[2*WIDTH-1:WIDTH];
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (!out_valid)     out_valid <= 1'b1;
          else if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Directed self-checking bench for alu_exec_ctrl (WIDTH=32).
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [5:0]  funct;
  logic [5:0]  opcode;
  logic [31:0] opa, opb;
  logic [4:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  control_out;
  logic [31:0] result, result_hi;
  logic        illegal, div_by_zero;

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct(funct), .opcode(opcode), .opa(opa), .opb(opb),
    .shamt(shamt), .out_valid(out_valid), .out_ready(out_ready),
    .control_out(control_out), .result(result), .result_hi(result_hi),
    .illegal(illegal), .div_by_zero(div_by_zero)
  );

  // Presents one request (unit must be idle), then counts edges until out_valid.
  task automatic start(input logic [1:0] op, input logic [5:0] fn, input logic [5:0] opc,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    alu_op = op; funct = fn; opcode = opc; opa = a; opb = b; shamt = sh;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = '0; funct = '0; opcode = '0; opa = '0; opb = '0; shamt = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b exp 0", out_valid); end
    checks++; if (control_out !== 4'd3) begin errors++; $display("FAIL reset control_out: got %0d exp 3", control_out); end
    checks++; if (result !== 32'h0 || result_hi !== 32'h0) begin errors++; $display("FAIL reset result: got %h/%h exp 0/0", result_hi, result); end
    checks++; if (illegal !== 1'b0 || div_by_zero !== 1'b0) begin errors++; $display("FAIL reset flags: got %b%b exp 00", illegal, div_by_zero); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b exp 1", in_ready); end
  endtask

  typedef struct packed {
    logic [1:0]  op;
    logic [5:0]  fn;
    logic [5:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [3:0]  code;
    logic [31:0] res;
  } vec_t;

  task automatic test_decode();
    vec_t v[17];
    v[0]  = '{2'b00, 6'h20, 6'h23, 32'd12, 32'd5, 5'd2, 4'd2,  32'd17};
    v[1]  = '{2'b01, 6'h25, 6'h04, 32'd12, 32'd5, 5'd2, 4'd6,  32'd7};
    v[2]  = '{2'b11, 6'h00, 6'h04, 32'd12, 32'd5, 5'd2, 4'd6,  32'd7};
    v[3]  = '{2'b10, 6'h20, 6'h00, 32'd12, 32'd5, 5'd2, 4'd2,  32'd17};
    v[4]  = '{2'b10, 6'h22, 6'h00, 32'd12, 32'd5, 5'd2, 4'd6,  32'd7};
    v[5]  = '{2'b10, 6'h24, 6'h00, 32'd12, 32'd5, 5'd2, 4'd0,  32'd4};
    v[6]  = '{2'b10, 6'h25, 6'h00, 32'd12, 32'd5, 5'd2, 4'd1,  32'd13};
    v[7]  = '{2'b10, 6'h2A, 6'h00, 32'hFFFFFFFF, 32'd1, 5'd2, 4'd7, 32'd1};
    v[8]  = '{2'b10, 6'h2A, 6'h00, 32'd12, 32'd5, 5'd2, 4'd7,  32'd0};
    v[9]  = '{2'b10, 6'h00, 6'h00, 32'd12, 32'd5, 5'd2, 4'd8,  32'd20};
    v[10] = '{2'b10, 6'h03, 6'h00, 32'd12, 32'h80000000, 5'd2, 4'd12, 32'hE0000000};
    v[11] = '{2'b10, 6'h02, 6'h00, 32'd12, 32'd5, 5'd2, 4'd9,  32'd1};
    v[12] = '{2'b10, 6'h26, 6'h00, 32'd12, 32'd5, 5'd2, 4'd10, 32'd9};
    v[13] = '{2'b10, 6'h27, 6'h00, 32'd12, 32'd5, 5'd2, 4'd11, 32'hFFFFFFF2};
    v[14] = '{2'b10, 6'h20, 6'h00, 32'hFFFFFFFF, 32'd1, 5'd0, 4'd2, 32'd0};
    v[15] = '{2'b01, 6'h00, 6'h04, 32'd0, 32'd1, 5'd0, 4'd6, 32'hFFFFFFFF};
    v[16] = '{2'b10, 6'h02, 6'h00, 32'd0, 32'h80000000, 5'd31, 4'd9, 32'd1};
    for (int i = 0; i < 17; i++) begin
      start(v[i].op, v[i].fn, v[i].opc, v[i].a, v[i].b, v[i].sh);
      checks++; if (lat !== 1) begin errors++; $display("FAIL decode[%0d] latency: got %0d exp 1", i, lat); end
      checks++; if (control_out !== v[i].code) begin errors++; $display("FAIL decode[%0d] control_out: got %0d exp %0d", i, control_out, v[i].code); end
      checks++; if (result !== v[i].res) begin errors++; $display("FAIL decode[%0d] result: got %h exp %h", i, result, v[i].res); end
      checks++; if (result_hi !== 32'h0 || illegal !== 1'b0) begin errors++; $display("FAIL decode[%0d] hi/illegal: got %h/%b exp 0/0", i, result_hi, illegal); end
      retire();
    end
  endtask

  task automatic test_mul();
    start(2'b10, 6'h02, 6'h1C, 32'hFFFFFFFF, 32'd2, 5'd0);
    checks++; if (lat !== 32) begin errors++; $display("FAIL mul latency: got %0d exp 32", lat); end
    checks++; if (control_out !== 4'd5) begin errors++; $display("FAIL mul control_out: got %0d exp 5", control_out); end
    checks++; if (result !== 32'hFFFFFFFE || result_hi !== 32'h1) begin errors++; $display("FAIL mul product: got %h_%h exp 00000001_fffffffe", result_hi, result); end
    retire();
    start(2'b10, 6'h02, 6'h1C, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
    checks++; if (result !== 32'h1 || result_hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL mul max: got %h_%h exp fffffffe_00000001", result_hi, result); end
    retire();
  endtask

  task automatic test_div();
    start(2'b10, 6'h1A, 6'h00, 32'd100, 32'd7, 5'd0);
    checks++; if (lat !== 32) begin errors++; $display("FAIL div latency: got %0d exp 32", lat); end
    checks++; if (control_out !== 4'd4) begin errors++; $display("FAIL div control_out: got %0d exp 4", control_out); end
    checks++; if (result !== 32'd14 || result_hi !== 32'd2) begin errors++; $display("FAIL div 100/7: got q=%0d r=%0d exp q=14 r=2", result, result_hi); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL div dbz flag: got %b exp 0", div_by_zero); end
    retire();
    start(2'b10, 6'h1A, 6'h00, 32'hFFFFFFFF, 32'h10, 5'd0);
    checks++; if (result !== 32'h0FFFFFFF || result_hi !== 32'hF) begin errors++; $display("FAIL div unsigned: got q=%h r=%h exp q=0fffffff r=f", result, result_hi); end
    retire();
    start(2'b10, 6'h1A, 6'h00, 32'd100, 32'd0, 5'd0);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dbz latency: got %0d exp 1", lat); end
    checks++; if (result !== 32'hFFFFFFFF || result_hi !== 32'd100 || div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz outputs: got %h/%0d/%b exp ffffffff/100/1", result, result_hi, div_by_zero); end
    retire();
    start(2'b00, 6'h00, 6'h23, 32'd1, 32'd2, 5'd0);
    checks++; if (div_by_zero !== 1'b0 || result !== 32'd3) begin errors++; $display("FAIL dbz clear: got dbz=%b res=%0d exp 0/3", div_by_zero, result); end
    retire();
  endtask

  task automatic test_illegal();
    start(2'b10, 6'h3F, 6'h00, 32'd12, 32'd5, 5'd2);
    checks++; if (lat !== 1) begin errors++; $display("FAIL illegal latency: got %0d exp 1", lat); end
    checks++; if (control_out !== 4'd3 || illegal !== 1'b1) begin errors++; $display("FAIL illegal decode: got code=%0d ill=%b exp 3/1", control_out, illegal); end
    checks++; if (result !== 32'h0 || result_hi !== 32'h0) begin errors++; $display("FAIL illegal result: got %h/%h exp 0/0", result_hi, result); end
    retire();
    start(2'b10, 6'h25, 6'h00, 32'd12, 32'd5, 5'd0);
    checks++; if (illegal !== 1'b0 || result !== 32'd13) begin errors++; $display("FAIL illegal clear: got ill=%b res=%0d exp 0/13", illegal, result); end
    retire();
  endtask

  task automatic test_backpressure();
    start(2'b00, 6'h00, 6'h23, 32'd12, 32'd5, 5'd0);
    for (int i = 0; i < 5; i++) begin
      alu_op = 2'b01; opa = 32'd1; opb = 32'd1; in_valid = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL stall[%0d] handshake: got ov=%b ir=%b exp 1/0", i, out_valid, in_ready); end
      checks++; if (result !== 32'd17 || control_out !== 4'd2) begin errors++; $display("FAIL stall[%0d] hold: got res=%0d code=%0d exp 17/2", i, result, control_out); end
    end
    in_valid = 1'b0;
    retire();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL stall release: got ov=%b ir=%b exp 0/1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    start(2'b00, 6'h00, 6'h23, 32'd12, 32'd5, 5'd0);
    checks++; if (lat !== 1 || result !== 32'd17) begin errors++; $display("FAIL b2b first: got lat=%0d res=%0d exp 1/17", lat, result); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b in_ready in done: got %b exp 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b retire: got ov=%b ir=%b exp 0/1", out_valid, in_ready); end
    start(2'b10, 6'h22, 6'h00, 32'd12, 32'd5, 5'd0);
    checks++; if (lat !== 1 || result !== 32'd7 || result_hi !== 32'd0) begin errors++; $display("FAIL b2b second: got lat=%0d res=%0d hi=%0d exp 1/7/0", lat, result, result_hi); end
    @(posedge clk); #1;
    start(2'b10, 6'h02, 6'h1C, 32'd7, 32'd6, 5'd0);
    checks++; if (lat !== 32 || result !== 32'd42 || result_hi !== 32'd0) begin errors++; $display("FAIL b2b early ready mul: got lat=%0d res=%0d hi=%0d exp 32/42/0", lat, result, result_hi); end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b final in_ready: got %b exp 1", in_ready); end
  endtask

  task automatic test_reset_mid_mul();
    alu_op = 2'b10; funct = 6'h02; opcode = 6'h1C; opa = 32'd3; opb = 32'd5;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || control_out !== 4'd5) begin errors++; $display("FAIL midmul busy: got ov=%b ir=%b code=%0d exp 0/0/5", out_valid, in_ready, control_out); end
    rst_n = 1'b0;
    #1;
    checks++; if (control_out !== 4'd3 || out_valid !== 1'b0) begin errors++; $display("FAIL midmul reset ctrl: got code=%0d ov=%b exp 3/0", control_out, out_valid); end
    checks++; if (result !== 32'h0 || result_hi !== 32'h0 || illegal !== 1'b0 || div_by_zero !== 1'b0) begin errors++; $display("FAIL midmul reset data: got %h/%h/%b/%b exp 0/0/0/0", result_hi, result, illegal, div_by_zero); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midmul in_ready: got %b exp 1", in_ready); end
    start(2'b00, 6'h00, 6'h23, 32'd12, 32'd5, 5'd0);
    checks++; if (lat !== 1 || result !== 32'd17 || control_out !== 4'd2) begin errors++; $display("FAIL midmul next add: got lat=%0d res=%0d code=%0d exp 1/17/2", lat, result, control_out); end
    retire();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_mul();
    test_div();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
